// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register offsets, CTRL bit layout, mode encodings and FSM states.
package timer_counter_pkg;

    localparam logic [1:0] TC_CTRL   = 2'd0;
    localparam logic [1:0] TC_PRESET = 2'd1;
    localparam logic [1:0] TC_COUNT  = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int MODE_W    = 2;
    localparam int CTRL_IM   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

endpackage

// File: rtl/timer_counter.sv
// Programmable countdown timer on the CPU bridge, driving HWInt[2].
// Define TC_AUTO_RELOAD_EN to compile MODE 01 (periodic auto-reload).
module timer_counter
    import timer_counter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    tc_state_e   state, state_nxt;

    logic en, ctrl_we, preset_we;
    logic load, dec, expire, en_clr, flag_clr;

    assign en        = ctrl[CTRL_EN];
    assign ctrl_we   = we && (addr == TC_CTRL);
    assign preset_we = we && (addr == TC_PRESET);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        expire    = 1'b0;
        en_clr    = 1'b0;
        flag_clr  = 1'b0;
        case (state)
            ST_IDLE: if (en) state_nxt = ST_LOAD;
            ST_LOAD: begin
                load      = 1'b1;
                state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (count > 32'd1) begin
                    dec = 1'b1;
                end else begin
                    expire    = 1'b1;
                    state_nxt = ST_INT;
                end
            end
            ST_INT: begin
`ifdef TC_AUTO_RELOAD_EN
                if (ctrl[CTRL_MODE +: MODE_W] == MODE_RELOAD) begin
                    flag_clr  = 1'b1;
                    state_nxt = ST_LOAD;
                end else
`endif
                begin
                    en_clr    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A CPU write to CTRL overrides both the one-shot EN clear and a
    // same-edge expiry, so the handler's write always lands cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            if (ctrl_we)     ctrl          <= wd[3:0];
            else if (en_clr) ctrl[CTRL_EN] <= 1'b0;

            if (preset_we) preset <= wd;

            if (load)        count <= preset;
            else if (dec)    count <= count - 32'd1;
            else if (expire) count <= '0;

            if (ctrl_we || flag_clr) irq_flag <= 1'b0;
            else if (expire)         irq_flag <= 1'b1;
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            TC_CTRL:   rd = {28'd0, ctrl};
            TC_PRESET: rd = preset;
            TC_COUNT:  rd = count;
            default:   rd = '0;
        endcase
    end

    assign irq = ctrl[CTRL_IM] & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; expected values are
// hand-derived edge by edge from the CTRL write edge E0.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        check(tag, rd, exp);
    endtask

    logic [31:0] exp_cnt [1:10];
    logic        exp_irq [1:10];

    initial begin
        // Reset state
        tick(2);
        reset = 1'b0;
        rd_chk(2'd0, 32'd0, "rst_ctrl");
        rd_chk(2'd1, 32'd0, "rst_preset");
        rd_chk(2'd2, 32'd0, "rst_count");
        rd_chk(2'd3, 32'd0, "rst_rsvd");
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Same-cycle read returns old value; reserved offset and upper CTRL bits ignored
        addr = 2'd1; wd = 32'd5; we = 1'b1;
        #1;
        check("rd_old_preset", rd, 32'd0);
        @(posedge clk); #1; we = 1'b0;
        rd_chk(2'd1, 32'd5, "preset_written");
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk(2'd3, 32'd0, "rsvd_reads_0");
        wr(2'd0, 32'hFFFF_FFF0);
        rd_chk(2'd0, 32'd0, "ctrl_upper_ignored");

        // One-shot, PRESET=5: irq after E7 and latched
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);            // E0
        tick(6);                    // after E6
        check("os_irq_e6", {31'd0, irq}, 32'd0);
        rd_chk(2'd2, 32'd1, "os_count_e6");
        tick(1);                    // after E7
        check("os_irq_e7", {31'd0, irq}, 32'd1);
        rd_chk(2'd2, 32'd0, "os_count_e7");
        tick(3);
        check("os_irq_held", {31'd0, irq}, 32'd1);
        rd_chk(2'd0, 32'h8, "os_en_cleared");
        wr(2'd0, 32'h0);
        check("os_irq_cleared", {31'd0, irq}, 32'd0);

        // MODE 01, PRESET=3
`ifdef TC_AUTO_RELOAD_EN
        exp_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);            // E0
        addr = 2'd2;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            check($sformatf("ar_count_e%0d", k), rd, exp_cnt[k]);
            check($sformatf("ar_irq_e%0d", k), {31'd0, irq}, {31'd0, exp_irq[k]});
        end
`ifdef TC_AUTO_RELOAD_EN
        rd_chk(2'd0, 32'hB, "ar_ctrl");
`else
        rd_chk(2'd0, 32'hA, "ar_ctrl_mode_kept");
`endif
        wr(2'd0, 32'h0);
        tick(3);
        check("ar_stopped_irq", {31'd0, irq}, 32'd0);

        // IM=0: expiry without irq, then IM=1 write clears the flag
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);            // E0
        tick(4);                    // after E4: expired
        rd_chk(2'd2, 32'd0, "nomask_count");
        check("nomask_irq", {31'd0, irq}, 32'd0);
        tick(1);
        wr(2'd0, 32'h8);
        check("mask_set_irq", {31'd0, irq}, 32'd0);
        tick(2);
        check("mask_set_irq_later", {31'd0, irq}, 32'd0);

        // Freeze mid-count and full reload on re-enable
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);            // E0
        tick(3);                    // after E3
        wr(2'd0, 32'h8);            // E4: COUNT=8
        tick(1);
        rd_chk(2'd2, 32'd8, "freeze_e5");
        tick(3);
        rd_chk(2'd2, 32'd8, "freeze_held");
        wr(2'd1, 32'd20);           // PRESET change while idle-frozen
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);            // F0
        tick(1);                    // F1: LOAD entered
        rd_chk(2'd2, 32'd8, "reen_f1");
        tick(1);                    // F2
        rd_chk(2'd2, 32'd10, "reen_reload");

        // PRESET write while counting does not disturb COUNT
        wr(2'd1, 32'd50);           // F3: COUNT=9
        rd_chk(2'd2, 32'd9, "preset_wr_mid");

        // COUNT is read-only
        tick(1);                    // F4: 8
        wr(2'd2, 32'h0000_FFFF);    // F5: 7
        rd_chk(2'd2, 32'd7, "count_ro");

        // Mid-count reset
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rd_chk(2'd0, 32'd0, "rst2_ctrl");
        rd_chk(2'd1, 32'd0, "rst2_preset");
        rd_chk(2'd2, 32'd0, "rst2_count");
        check("rst2_irq", {31'd0, irq}, 32'd0);
        tick(3);
        rd_chk(2'd2, 32'd0, "rst2_idle_count");

        // PRESET=0 behaves as 1: irq after E3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);            // E0
        tick(2);
        check("p0_irq_e2", {31'd0, irq}, 32'd0);
        tick(1);
        check("p0_irq_e3", {31'd0, irq}, 32'd1);
        rd_chk(2'd2, 32'd0, "p0_count_e3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable timer that raises hardware interrupt `HWInt[2]` for the pipelined CPU. It sits on the processor bridge: it takes word-address, write-enable and write-data from the CPU's `PrAddr`/`PrWE`/`PrWD` after bridge decode, and returns `PrRD` read data. It counts down from a preset value and asserts `irq` on expiry, either once or periodically with auto-reload. Its interrupt is sampled by CP0 in the Memory stage.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high; clears all state on the rising edge where it is high.
- `addr` in 2: word offset, equal to `PrAddr[3:2]`. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` in 1: write strobe. The bridge gates this with its device select.
- `wd` in 32: write data.
- `rd` out 32: read data, combinational from `addr`.
- `irq` out 1: interrupt request to `HWInt[2]`, equal to `IM & irq_flag`.

## Operation
- CTRL[3:0] is read/write:
  - bit 0 = EN.
  - bits [2:1] = MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - bit 3 = IM (interrupt mask).
  - Bits [31:4] read 0 and writes to them are ignored.
- PRESET[31:0] is read/write.
- COUNT[31:0] is read-only; writes to it are ignored.
- Offset 3 reads 0.
- FSM states: IDLE, LOAD, CNT, INT. Transitions, evaluated at each edge:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !EN, go to IDLE with COUNT held;
    - else if COUNT > 1, decrement COUNT;
    - else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - MODE 00: EN <= 0, go to IDLE; irq_flag stays set.
    - MODE 01: irq_flag <= 0, go to LOAD.
- irq_flag is cleared by reset, by any CTRL write, or on leaving INT in MODE 01.
- A CTRL write in the same cycle as the INT-state EN clear: the CPU write wins.
- A PRESET write while counting does not affect the current COUNT; it takes effect at the next LOAD.
- PRESET 0 behaves as PRESET 1: the first CNT cycle expires.
- Decrement is unsigned 32-bit. There is no wrap, because expiry occurs at 1 → 0.
- Reset during any state: state = IDLE; CTRL, PRESET, COUNT and irq_flag = 0; `irq` = 0.

## Timing
- Reset values: `irq` = 0, `rd` = 0 for all addresses.
- A write updates its register at the edge where `we` is high. A read in the same cycle returns the old value.
- Latency from the CTRL edge that sets EN=1 (edge E0), with PRESET = N ≥ 1:
  - LOAD entered at E1;
  - COUNT = N after E2;
  - COUNT = 0 and `irq` high (if IM) after edge E(N+2).
- MODE 01 period is N+2 cycles. `irq` is a 1-cycle pulse per period, high during INT.
- MODE 00: `irq` stays high until a CTRL write or reset. CP0 handler clears it by writing CTRL.
- Clearing EN mid-count: COUNT freezes within 1 cycle of the write edge. Re-enabling restarts from LOAD, i.e. a full reload, not a resume.
- `irq` is registered-only: it is a function of IM and irq_flag, with no combinational path from `we`/`wd`.

## Configuration
- `TC_AUTO_RELOAD_EN` defined: MODE 01 behaves as above.
- Undefined: every MODE value behaves as 00. MODE bits are still stored and readable. The INT → LOAD path and its logic are not compiled.

## Structure
- Shared package/header holds:
  - register offset constants `TC_CTRL`, `TC_PRESET`, `TC_COUNT`;
  - CTRL bit positions (EN, MODE, IM);
  - mode encodings;
  - the FSM state encoding as a 2-bit enum/localparam set.
- Single module, no sub-module. The register file and FSM are small enough to keep flat.

## Test plan
- Reset, then read all offsets → 0; `irq` = 0.
- PRESET = 5, CTRL = 0x9 (EN, IM, mode 0) → `irq` rises after the 7th edge from the CTRL write edge and stays high. CTRL reads 0x8 (EN cleared). Writing CTRL = 0 drops `irq` next cycle.
- PRESET = 3, CTRL = 0xB (mode 01, `TC_AUTO_RELOAD_EN` defined) → `irq` is a 1-cycle pulse every 5 cycles. COUNT sequence is 3,2,1,0 repeating.
- Count with IM = 0 → expiry at the same cycle, but `irq` stays 0. Setting IM = 1 via CTRL write clears irq_flag, so `irq` stays 0.
- PRESET = 10, enable, then after 4 cycles write CTRL = 0x8 → COUNT freezes at its value. Re-enabling reloads 10.
- Mid-count reset, and a write to COUNT with 0xFFFF → COUNT is unaffected by the write. Reset returns everything to 0. PRESET = 0 → `irq` at edge E3.
